// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX pipeline register stage.
// Defines the control word layout, ALU op encodings and the per-cycle action priority.
package id_ex_stage_pkg;

    localparam int unsigned DataWDef = 32;
    localparam int unsigned RegAwDef = 5;
    localparam int unsigned CntWDef  = 16;
    localparam int unsigned CtrlW    = 9;

    // Control word bit positions, MSB first
    localparam int unsigned CtrlRegWrite = 8;
    localparam int unsigned CtrlMemRead  = 7;
    localparam int unsigned CtrlMemWrite = 6;
    localparam int unsigned CtrlMemToReg = 5;
    localparam int unsigned CtrlRegDst   = 4;
    localparam int unsigned CtrlAluSrc   = 3;
    localparam int unsigned CtrlAluOpHi  = 2;
    localparam int unsigned CtrlAluOpLo  = 0;

    typedef enum logic [2:0] {
        AluAdd = 3'd0,
        AluSub = 3'd1,
        AluAnd = 3'd2,
        AluOr  = 3'd3,
        AluXor = 3'd4,
        AluSlt = 3'd5,
        AluLui = 3'd6,
        AluNor = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    reg_dst;
        logic    alu_src;
        alu_op_e alu_op;
    } ctrl_t;

    typedef enum logic [1:0] {
        ActCapture,
        ActHold,
        ActBubble,
        ActFlush
    } action_e;

    // Exactly one action per cycle; reset is applied on top of this in the register process.
    function automatic action_e select_action(logic flush, logic ext_stall, logic hazard);
        if (flush) begin
            return ActFlush;
        end else if (ext_stall) begin
            return ActHold;
        end else if (hazard) begin
            return ActBubble;
        end
        return ActCapture;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of decode-side inputs, write-back port and EX-side outputs of the ID/EX stage.
interface id_ex_stage_if
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDef,
    parameter int unsigned REG_AW = RegAwDef,
    parameter int unsigned CNT_W  = CntWDef
) ();

    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic [DATA_W-1:0] bus_a;
    logic [DATA_W-1:0] bus_b;
    logic [15:0]       id_imm;
    logic              id_sign_ext;
    logic [CtrlW-1:0]  id_ctrl;

    logic              wb_reg_write;
    logic [REG_AW-1:0] wb_rw;
    logic [DATA_W-1:0] wb_data;

    logic              flush;
    logic              ext_stall;

    logic              ex_valid;
    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;
    logic [DATA_W-1:0] ex_imm;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_dest;
    logic [CtrlW-1:0]  ex_ctrl;
    logic              stall_if;
    logic [CNT_W-1:0]  bubble_count;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, bus_a, bus_b, id_imm, id_sign_ext, id_ctrl,
        output wb_reg_write, wb_rw, wb_data, flush, ext_stall,
        input  ex_valid, ex_a, ex_b, ex_imm, ex_rs, ex_rt, ex_dest, ex_ctrl,
        input  stall_if, bubble_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, bus_a, bus_b, id_imm, id_sign_ext, id_ctrl,
        input  wb_reg_write, wb_rw, wb_data, flush, ext_stall,
        output ex_valid, ex_a, ex_b, ex_imm, ex_rs, ex_rt, ex_dest, ex_ctrl,
        output stall_if, bubble_count
    );

endinterface

// File: rtl/id_ex_stage_hazard_unit.sv
// Load-use hazard detection and IF/ID stall request; purely combinational.
module id_ex_stage_hazard_unit
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned REG_AW = RegAwDef
) (
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              flush,
    input  logic              ext_stall,
    output logic              hazard,
    output logic              stall_if
);

    logic src_match;

    assign src_match = (ex_rt == id_rs) || (ex_rt == id_rt);

    // A load into r0 never produces a value, so it cannot create a dependency.
    assign hazard = id_valid && ex_valid && ex_mem_read && (ex_rt != '0) && src_match;

    assign stall_if = !flush && (ext_stall || hazard);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, WB bypass and a saturating
// bubble counter. All state lives here; hazard detection is in the hazard unit.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDef,
    parameter int unsigned REG_AW = RegAwDef,
    parameter int unsigned CNT_W  = CntWDef
) (
    input logic          clk,
    input logic          reset,
    id_ex_stage_if.slave bus
);

    logic              ex_valid_q, ex_valid_d;
    logic [CtrlW-1:0]  ex_ctrl_q, ex_ctrl_d;
    logic [DATA_W-1:0] ex_a_q, ex_a_d;
    logic [DATA_W-1:0] ex_b_q, ex_b_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
    logic [REG_AW-1:0] ex_rs_q, ex_rs_d;
    logic [REG_AW-1:0] ex_rt_q, ex_rt_d;
    logic [REG_AW-1:0] ex_dest_q, ex_dest_d;
    logic [CNT_W-1:0]  bubble_count_q, bubble_count_d;

    logic              hazard;
    logic              stall_if;
    action_e           act;
    ctrl_t             id_ctrl;

    logic              rs_bypass;
    logic              rt_bypass;
    logic [DATA_W-1:0] cap_a;
    logic [DATA_W-1:0] cap_b;
    logic [DATA_W-1:0] cap_imm;
    logic [REG_AW-1:0] cap_dest;

    id_ex_stage_hazard_unit #(
        .REG_AW (REG_AW)
    ) hazard_unit (
        .id_valid    (bus.id_valid),
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .ex_valid    (ex_valid_q),
        .ex_mem_read (ex_ctrl_q[CtrlMemRead]),
        .ex_rt       (ex_rt_q),
        .flush       (bus.flush),
        .ext_stall   (bus.ext_stall),
        .hazard      (hazard),
        .stall_if    (stall_if)
    );

    assign act     = select_action(bus.flush, bus.ext_stall, hazard);
    assign id_ctrl = ctrl_t'(bus.id_ctrl);

    // The register bank is written this same cycle, so forward the WB value ourselves.
    assign rs_bypass = bus.wb_reg_write && (bus.wb_rw != '0) && (bus.wb_rw == bus.id_rs);
    assign rt_bypass = bus.wb_reg_write && (bus.wb_rw != '0) && (bus.wb_rw == bus.id_rt);

    assign cap_a    = rs_bypass ? bus.wb_data : bus.bus_a;
    assign cap_b    = rt_bypass ? bus.wb_data : bus.bus_b;
    assign cap_imm  = {{(DATA_W-16){bus.id_sign_ext & bus.id_imm[15]}}, bus.id_imm};
    assign cap_dest = id_ctrl.reg_dst ? bus.id_rd : bus.id_rt;

    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_ctrl_d      = ex_ctrl_q;
        ex_a_d         = ex_a_q;
        ex_b_d         = ex_b_q;
        ex_imm_d       = ex_imm_q;
        ex_rs_d        = ex_rs_q;
        ex_rt_d        = ex_rt_q;
        ex_dest_d      = ex_dest_q;
        bubble_count_d = bubble_count_q;

        unique case (act)
            ActFlush: begin
                ex_valid_d = 1'b0;
                ex_ctrl_d  = '0;
            end
            ActHold: begin
            end
            ActBubble: begin
                ex_valid_d = 1'b0;
                ex_ctrl_d  = '0;
                if (bubble_count_q != {CNT_W{1'b1}}) begin
                    bubble_count_d = bubble_count_q + CNT_W'(1);
                end
            end
            ActCapture: begin
                ex_valid_d = bus.id_valid;
                // Invalid slots carry no control so they can never write state downstream.
                ex_ctrl_d  = bus.id_valid ? bus.id_ctrl : '0;
                ex_a_d     = cap_a;
                ex_b_d     = cap_b;
                ex_imm_d   = cap_imm;
                ex_rs_d    = bus.id_rs;
                ex_rt_d    = bus.id_rt;
                ex_dest_d  = cap_dest;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q     <= 1'b0;
            ex_ctrl_q      <= '0;
            ex_a_q         <= '0;
            ex_b_q         <= '0;
            ex_imm_q       <= '0;
            ex_rs_q        <= '0;
            ex_rt_q        <= '0;
            ex_dest_q      <= '0;
            bubble_count_q <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_ctrl_q      <= ex_ctrl_d;
            ex_a_q         <= ex_a_d;
            ex_b_q         <= ex_b_d;
            ex_imm_q       <= ex_imm_d;
            ex_rs_q        <= ex_rs_d;
            ex_rt_q        <= ex_rt_d;
            ex_dest_q      <= ex_dest_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_ctrl      = ex_ctrl_q;
    assign bus.ex_a         = ex_a_q;
    assign bus.ex_b         = ex_b_q;
    assign bus.ex_imm       = ex_imm_q;
    assign bus.ex_rs        = ex_rs_q;
    assign bus.ex_rt        = ex_rt_q;
    assign bus.ex_dest      = ex_dest_q;
    assign bus.stall_if     = stall_if;
    assign bus.bubble_count = bubble_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; a second instance with a 4-bit counter covers saturation.
module tb_id_ex_stage;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    id_ex_stage_if #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) bus ();
    id_ex_stage_if #(.DATA_W(32), .REG_AW(5), .CNT_W(4))  sbus ();

    id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (sbus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input int v, input int rs, input int rt, input int rd,
                          input int a, input int b, input int imm, input int sx,
                          input int ctrl);
        bus.id_valid    = 1'(v);
        bus.id_rs       = 5'(rs);
        bus.id_rt       = 5'(rt);
        bus.id_rd       = 5'(rd);
        bus.bus_a       = 32'(a);
        bus.bus_b       = 32'(b);
        bus.id_imm      = 16'(imm);
        bus.id_sign_ext = 1'(sx);
        bus.id_ctrl     = 9'(ctrl);
    endtask

    initial begin
        reset = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.wb_reg_write  = 1'b0;
        bus.wb_rw         = '0;
        bus.wb_data       = '0;
        bus.flush         = 1'b0;
        bus.ext_stall     = 1'b0;
        sbus.id_valid     = 1'b0;
        sbus.id_rs        = '0;
        sbus.id_rt        = '0;
        sbus.id_rd        = '0;
        sbus.bus_a        = '0;
        sbus.bus_b        = '0;
        sbus.id_imm       = '0;
        sbus.id_sign_ext  = 1'b0;
        sbus.id_ctrl      = '0;
        sbus.wb_reg_write = 1'b0;
        sbus.wb_rw        = '0;
        sbus.wb_data      = '0;
        sbus.flush        = 1'b0;
        sbus.ext_stall    = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        chk("rst_valid", 32'(bus.ex_valid), 0);
        chk("rst_ctrl", 32'(bus.ex_ctrl), 0);
        chk("rst_a", bus.ex_a, 0);
        chk("rst_imm", bus.ex_imm, 0);
        chk("rst_dest", 32'(bus.ex_dest), 0);
        chk("rst_cnt", 32'(bus.bubble_count), 0);
        chk("rst_stall", 32'(bus.stall_if), 0);

        // Capture with sign extension and reg_dst=1 (ctrl: reg_write, reg_dst, alu_op=2)
        set_id(1, 3, 4, 9, 'h11, 'h22, 'h8000, 1, 'h112);
        step();
        chk("cap_valid", 32'(bus.ex_valid), 1);
        chk("cap_a", bus.ex_a, 'h11);
        chk("cap_b", bus.ex_b, 'h22);
        chk("cap_imm_sx", bus.ex_imm, 32'hFFFF_8000);
        chk("cap_dest_rd", 32'(bus.ex_dest), 9);
        chk("cap_ctrl", 32'(bus.ex_ctrl), 'h112);

        // Zero extension, reg_dst=0 -> dest is rt
        set_id(1, 3, 4, 9, 'h33, 'h44, 'h8000, 0, 'h100);
        step();
        chk("cap_imm_zx", bus.ex_imm, 32'h0000_8000);
        chk("cap_dest_rt", 32'(bus.ex_dest), 4);

        // Load-use: lw r5 in EX, ID reads r5 through rs
        set_id(1, 1, 5, 0, 'h10, 'h50, 4, 1, 'h1A8);
        step();
        chk("lw_rt", 32'(bus.ex_rt), 5);
        set_id(1, 5, 6, 7, 'h55, 'h66, 0, 1, 'h112);
        #1;
        chk("lu_stall", 32'(bus.stall_if), 1);
        step();
        chk("lu_bub_valid", 32'(bus.ex_valid), 0);
        chk("lu_bub_ctrl", 32'(bus.ex_ctrl), 0);
        chk("lu_bub_cnt", 32'(bus.bubble_count), 1);
        chk("lu_bub_rt_hold", 32'(bus.ex_rt), 5);
        chk("lu_stall_clear", 32'(bus.stall_if), 0);
        step();
        chk("lu_cap_valid", 32'(bus.ex_valid), 1);
        chk("lu_cap_a", bus.ex_a, 'h55);
        chk("lu_cap_rs", 32'(bus.ex_rs), 5);
        chk("lu_cap_dest", 32'(bus.ex_dest), 7);

        // A load into r0 is never a hazard
        set_id(1, 2, 0, 0, 0, 0, 0, 0, 'h1A8);
        step();
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 'h100);
        #1;
        chk("lw_r0_nostall", 32'(bus.stall_if), 0);

        // WB bypass on rs, then r0 never bypassed, then rt bypass, then no write enable
        bus.wb_reg_write = 1'b1;
        bus.wb_rw        = 5'd7;
        bus.wb_data      = 32'hDEAD;
        set_id(1, 7, 8, 3, 0, 'h88, 0, 0, 'h100);
        step();
        chk("byp_rs_a", bus.ex_a, 32'hDEAD);
        chk("byp_rs_b", bus.ex_b, 'h88);
        bus.wb_rw = 5'd0;
        set_id(1, 0, 8, 3, 'h1234, 'h88, 0, 0, 'h100);
        step();
        chk("byp_r0_a", bus.ex_a, 'h1234);
        bus.wb_rw   = 5'd8;
        bus.wb_data = 32'hBEEF;
        set_id(1, 8, 8, 3, 1, 2, 0, 0, 'h100);
        step();
        chk("byp_rt_a", bus.ex_a, 32'hBEEF);
        chk("byp_rt_b", bus.ex_b, 32'hBEEF);
        bus.wb_reg_write = 1'b0;
        set_id(1, 8, 9, 3, 3, 4, 0, 0, 'h100);
        step();
        chk("byp_off_a", bus.ex_a, 3);

        // Priority: flush + ext_stall + hazard together
        set_id(1, 0, 5, 0, 0, 0, 0, 0, 'h1A8);
        step();
        set_id(1, 5, 0, 0, 0, 0, 0, 0, 'h100);
        bus.flush     = 1'b1;
        bus.ext_stall = 1'b1;
        #1;
        chk("pri_stall", 32'(bus.stall_if), 0);
        step();
        chk("pri_valid", 32'(bus.ex_valid), 0);
        chk("pri_ctrl", 32'(bus.ex_ctrl), 0);
        chk("pri_cnt", 32'(bus.bubble_count), 1);
        bus.flush     = 1'b0;
        bus.ext_stall = 1'b0;

        // ext_stall with a pending hazard: hold, no bubble; release -> bubble, then capture
        set_id(1, 0, 5, 0, 0, 0, 0, 0, 'h1A8);
        step();
        set_id(1, 6, 5, 2, 'h77, 'h78, 0, 0, 'h112);
        bus.ext_stall = 1'b1;
        #1;
        chk("xs_hz_stall", 32'(bus.stall_if), 1);
        step();
        chk("xs_hz_cnt", 32'(bus.bubble_count), 1);
        chk("xs_hz_valid", 32'(bus.ex_valid), 1);
        chk("xs_hz_ctrl", 32'(bus.ex_ctrl), 'h1A8);
        bus.ext_stall = 1'b0;
        #1;
        chk("hz_rt_stall", 32'(bus.stall_if), 1);
        step();
        chk("hz_rt_cnt", 32'(bus.bubble_count), 2);
        chk("hz_rt_valid", 32'(bus.ex_valid), 0);
        step();
        chk("hz_rt_cap_a", bus.ex_a, 'h77);
        chk("hz_rt_cap_dest", 32'(bus.ex_dest), 2);

        // ext_stall for 3 cycles holds EX, then the ID instruction captures
        set_id(1, 10, 11, 12, 'hC3, 'hD4, 'h7FFF, 1, 'h100);
        bus.ext_stall = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("xs3_stall", 32'(bus.stall_if), 1);
            step();
            chk("xs3_a_hold", bus.ex_a, 'h77);
            chk("xs3_rs_hold", 32'(bus.ex_rs), 6);
            chk("xs3_ctrl_hold", 32'(bus.ex_ctrl), 'h112);
        end
        bus.ext_stall = 1'b0;
        step();
        chk("xs3_rel_a", bus.ex_a, 'hC3);
        chk("xs3_rel_rs", 32'(bus.ex_rs), 10);
        chk("xs3_rel_imm", bus.ex_imm, 'h7FFF);

        // id_valid=0 capture: no control, data still loaded
        set_id(0, 1, 2, 3, 9, 9, 0, 0, 'h1FF);
        step();
        chk("inv_valid", 32'(bus.ex_valid), 0);
        chk("inv_ctrl", 32'(bus.ex_ctrl), 0);
        chk("inv_a", bus.ex_a, 9);

        // Reset during a load-use stall discards everything
        set_id(1, 0, 5, 0, 0, 0, 0, 0, 'h1A8);
        step();
        set_id(1, 5, 0, 0, 0, 0, 0, 0, 'h100);
        #1;
        chk("rs_pre_stall", 32'(bus.stall_if), 1);
        reset = 1'b1;
        step();
        chk("rs_mid_valid", 32'(bus.ex_valid), 0);
        chk("rs_mid_cnt", 32'(bus.bubble_count), 0);
        chk("rs_mid_rt", 32'(bus.ex_rt), 0);
        chk("rs_mid_stall", 32'(bus.stall_if), 0);
        reset = 1'b0;

        // Saturation (4-bit counter): constant self-dependent lw gives one bubble per 2 cycles
        sbus.id_valid = 1'b1;
        sbus.id_rs    = 5'd5;
        sbus.id_rt    = 5'd5;
        sbus.id_ctrl  = 9'h1A8;
        repeat (30) step();
        chk("sat_reach", 32'(sbus.bubble_count), 15);
        repeat (2) step();
        chk("sat_hold", 32'(sbus.bubble_count), 15);
        repeat (6) step();
        chk("sat_hold2", 32'(sbus.bubble_count), 15);
        reset = 1'b1;
        step();
        chk("sat_reset", 32'(sbus.bubble_count), 0);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath width.
REQ-002 Parameter REG_AW, default 5, register-address width.
REQ-003 Parameter CNT_W, default 16, bubble-counter width.
REQ-004 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 id_valid  in  1  ID holds a real instruction this cycle.
REQ-008 id_rs, id_rt, id_rd  in  REG_AW each  decoded register fields.
REQ-009 bus_a, bus_b  in  DATA_W each  register-bank read data for rs/rt.
REQ-010 id_imm  in  16  raw immediate; id_sign_ext  in  1  1=sign-extend, 0=zero-extend.
REQ-011 id_ctrl  in  9  {reg_write, mem_read, mem_write, mem_to_reg, reg_dst, alu_src, alu_op[2:0]}.
REQ-012 wb_reg_write  in  1, wb_rw  in  REG_AW, wb_data  in  DATA_W  write-back port, same values driven to the register bank.
REQ-013 flush  in  1  branch/jump squash of the ID instruction.
REQ-014 ext_stall  in  1  downstream (EX/MEM) cannot accept.
REQ-015 ex_valid  out  1; ex_a, ex_b, ex_imm  out  DATA_W each; ex_rs, ex_rt, ex_dest  out  REG_AW each; ex_ctrl  out  9.
REQ-016 stall_if  out  1  combinational: hold PC and IF/ID register.
REQ-017 bubble_count  out  CNT_W  saturating count of inserted load-use bubbles.

Function
REQ-018 Each cycle SHALL take exactly one action, priority: reset > flush > ext_stall > hazard > capture.
REQ-019 hazard SHALL be 1 iff id_valid & ex_valid & ex_ctrl.mem_read & ex_rt != 0 & (ex_rt == id_rs | ex_rt == id_rt).
REQ-020 stall_if SHALL equal ~flush & (ext_stall | hazard), combinationally in the same cycle.
REQ-021 Capture: ex_valid <= id_valid; all fields loaded; latency 1 cycle ID->EX.
REQ-022 ex_dest SHALL be id_rd when reg_dst=1, else id_rt, resolved at capture.
REQ-023 ex_imm SHALL be {16{id_imm[15]}},id_imm when id_sign_ext=1, else 16 zeros,id_imm.
REQ-024 WB bypass: on capture, if wb_reg_write & wb_rw != 0 & wb_rw == id_rs, ex_a <= wb_data, else bus_a; same rule for id_rt/ex_b.
REQ-025 Bypass SHALL never apply for register 0; ex_a SHALL be bus_a when id_rs = 0.
REQ-026 If id_valid=0 on capture, ex_valid <= 0 and ex_ctrl <= 0; data fields don't-care but deterministic (loaded).
REQ-027 Hazard: insert bubble: ex_valid <= 0, ex_ctrl <= 0, other fields hold; bubble_count increments by 1.
REQ-028 bubble_count SHALL saturate at all-ones and never wrap.
REQ-029 ext_stall (no flush): every ex_* register SHALL hold; no bubble counted even if hazard also true.
REQ-030 flush: ex_valid <= 0, ex_ctrl <= 0; wins over ext_stall and hazard; stall_if = 0; no bubble counted.
REQ-031 A hazard SHALL clear after one bubble, since ex_valid=0 then; the stalled instruction captures next cycle with bus_a/bus_b or WB bypass values.
REQ-032 ex_ctrl SHALL be 0 whenever ex_valid = 0, so no bubble can write registers or memory.

Reset
REQ-033 On reset: ex_valid=0, ex_ctrl=0, ex_a=ex_b=ex_imm=0, ex_rs=ex_rt=ex_dest=0, bubble_count=0.
REQ-034 Reset mid-stall SHALL discard the held instruction; stall_if SHALL follow REQ-020 from the reset values (0 with ext_stall=0).
REQ-035 Reset SHALL not depend on any other input.

Structure
REQ-036 Shared package: DATA_W/REG_AW defaults, ctrl-field bit indices, ctrl width 9, alu_op encodings.
REQ-037 Sub-module hazard_unit SHALL hold the REQ-019 compare and REQ-020 stall_if logic, purely combinational; id_ex_stage holds all registers.

Verification
REQ-038 Capture: id_valid=1, rs=3, rt=4, bus_a=0x11, bus_b=0x22, imm=0x8000, sign_ext=1 -> next cycle ex_a=0x11, ex_b=0x22, ex_imm=0xFFFF8000, ex_valid=1.
REQ-039 Load-use: EX holds lw with ex_rt=5; ID has rs=5 -> stall_if=1, next ex_valid=0, bubble_count=1; following cycle the instruction captures, stall_if=0.
REQ-040 WB bypass: wb_reg_write=1, wb_rw=7, wb_data=0xDEAD, id_rs=7, bus_a=0x0 -> ex_a=0xDEAD; repeat with wb_rw=0, id_rs=0 -> ex_a=bus_a.
REQ-041 Priority: flush=1, ext_stall=1, hazard true together -> ex_valid=0, stall_if=0, bubble_count unchanged.
REQ-042 ext_stall for 3 cycles -> ex_* constant for 3 cycles, stall_if=1 all 3 cycles; the ID instruction captures on release.
REQ-043 Saturation: preload by 65535 hazards -> bubble_count=0xFFFF; one further hazard -> still 0xFFFF; reset -> 0.
